spi_shift_engine: RTL and testbench

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

---
 rtl/spi_shift_engine.sv | 135 +++++++++++++
 tb/tb_spi_shift_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte shifter with selectable sclk rate and a CRC-16/XMODEM
// that runs over either the transmitted or the received bit stream.
module spi_shift_engine #(
  parameter int SLOW_HALF = 128,
  parameter int MED_HALF  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_write,
  input  logic        start_read,
  input  logic [7:0]  shift_in,
  output logic [7:0]  shift_out,
  input  logic [1:0]  speed,
  input  logic        crc_reset,
  input  logic        crc_source,
  output logic [15:0] crc_out,
  input  logic        miso,
  output logic        mosi,
  output logic        sclk,
  output logic        busy
);

  localparam int MAX_HALF = (SLOW_HALF > MED_HALF) ? SLOW_HALF : MED_HALF;
  localparam int CNT_W    = $clog2(MAX_HALF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] reload;
  logic [7:0]       tx;
  logic [7:0]       rx;
  logic             src;
  logic             half_done;

  // Counter is loaded with H-1 and a phase ends on the cycle it reads zero.
  function automatic logic [CNT_W-1:0] half_reload(input logic [1:0] spd);
    case (spd)
      2'b00:   half_reload = CNT_W'(SLOW_HALF - 1);
      2'b01:   half_reload = CNT_W'(MED_HALF - 1);
      2'b10:   half_reload = CNT_W'(1);
      default: half_reload = CNT_W'(0);
    endcase
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic d);
    logic fb;
    fb = crc[15] ^ d;
    crc_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign half_done = (half_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      half_cnt  <= '0;
      reload    <= '0;
      tx        <= '0;
      rx        <= '0;
      src       <= 1'b0;
      shift_out <= '0;
      crc_out   <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b1;
      busy      <= 1'b0;
    end else begin
      // CRC advances once per bit on the LOW->HIGH edge; a clear request wins.
      if (crc_reset)
        crc_out <= '0;
      else if (state == LOW && half_done)
        crc_out <= crc_step(crc_out, src ? miso : mosi);

      case (state)
        IDLE: begin
          if (start_write || start_read) begin
            tx       <= start_write ? shift_in : 8'hFF;
            mosi     <= start_write ? shift_in[7] : 1'b1;
            reload   <= half_reload(speed);
            half_cnt <= half_reload(speed);
            bit_cnt  <= 3'd7;
            src      <= crc_source;
            busy     <= 1'b1;
            sclk     <= 1'b0;
            state    <= LOW;
          end
        end

        LOW: begin
          if (half_done) begin
            rx[bit_cnt] <= miso;
            half_cnt    <= reload;
            sclk        <= 1'b1;
            state       <= HIGH;
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end

        HIGH: begin
          if (half_done) begin
            sclk <= 1'b0;
            if (bit_cnt != 3'd0) begin
              bit_cnt  <= bit_cnt - 3'd1;
              mosi     <= tx[bit_cnt - 3'd1];
              half_cnt <= reload;
              state    <= LOW;
            end else begin
              shift_out <= rx;
              mosi      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end

        default: begin
          sclk  <= 1'b0;
          mosi  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: vector table of transfers plus
// hand-written CRC, ignored-start, slow-speed and async-reset sequences.
module tb_spi_shift_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_write;
  logic        start_read;
  logic [7:0]  shift_in;
  logic [7:0]  shift_out;
  logic [1:0]  speed;
  logic        crc_reset;
  logic        crc_source;
  logic [15:0] crc_out;
  logic        miso;
  logic        mosi;
  logic        sclk;
  logic        busy;

  int          n_cmp = 0;
  int          n_fail = 0;

  logic        loopback;
  logic [7:0]  mbyte;
  int          rises;

  always #5 clk = ~clk;

  // Slave model: presents mbyte MSB first, advancing after each sclk rise.
  always_comb begin
    miso = 1'b1;
    if (loopback)
      miso = mosi;
    else if (rises < 8)
      miso = mbyte[3'(7 - rises)];
  end

  spi_shift_engine dut (
    .clk         (clk),
    .rst         (rst),
    .start_write (start_write),
    .start_read  (start_read),
    .shift_in    (shift_in),
    .shift_out   (shift_out),
    .speed       (speed),
    .crc_reset   (crc_reset),
    .crc_source  (crc_source),
    .crc_out     (crc_out),
    .miso        (miso),
    .mosi        (mosi),
    .sclk        (sclk),
    .busy        (busy)
  );

  typedef struct {
    logic       w;
    logic       r;
    logic [1:0] spd;
    logic [7:0] din;
    logic [7:0] mb;
    int         bc;
    logic [7:0] emosi;
    logic [7:0] eso;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic r, input logic [1:0] spd,
                      input logic [7:0] din, input logic [7:0] mb, input int inj,
                      output int bcyc, output logic [7:0] mcap, output int nrise,
                      output logic all1, output logic held);
    logic       prev;
    logic       cs0;
    logic [7:0] so0;
    mbyte = mb;
    rises = 0;
    so0   = shift_out;
    cs0   = crc_source;
    held  = 1'b1;
    all1  = 1'b1;
    mcap  = 8'h00;
    nrise = 0;
    bcyc  = 0;
    prev  = 1'b0;
    start_write = w;
    start_read  = r;
    speed       = spd;
    shift_in    = din;
    @(negedge clk);
    start_write = 1'b0;
    start_read  = 1'b0;
    speed       = ~spd;
    shift_in    = ~din;
    crc_source  = ~cs0;
    while (busy && bcyc < 5000) begin
      bcyc++;
      if (sclk && !prev) begin
        mcap = {mcap[6:0], mosi};
        nrise++;
        rises++;
      end
      if (!mosi) all1 = 1'b0;
      if (shift_out !== so0) held = 1'b0;
      prev = sclk;
      start_read = (bcyc == inj);
      @(negedge clk);
    end
    start_read = 1'b0;
    crc_source = cs0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         bcyc;
    int         nrise;
    int         n;
    logic [7:0] mcap;
    logic       all1;
    logic       held;

    vecs[0] = '{1'b1, 1'b0, 2'd3, 8'hA5, 8'h00, 16,  8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 2'd2, 8'h12, 8'h3C, 32,  8'hFF, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 2'd1, 8'h0F, 8'hF0, 128, 8'h0F, 8'hF0};
    vecs[3] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'hFF, 16,  8'h00, 8'hFF};
    vecs[4] = '{1'b1, 1'b1, 2'd2, 8'h81, 8'h55, 32,  8'h81, 8'h55};
    vecs[5] = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h81, 16,  8'hFF, 8'h81};

    rst = 1'b1;
    start_write = 1'b0;
    start_read  = 1'b0;
    shift_in    = 8'h00;
    speed       = 2'd0;
    crc_reset   = 1'b0;
    crc_source  = 1'b0;
    loopback    = 1'b0;
    mbyte       = 8'h00;
    rises       = 8;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_shift_out", 32'(shift_out), 32'h00);
    check("rst_crc", 32'(crc_out), 32'h0000);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].w, vecs[i].r, vecs[i].spd, vecs[i].din, vecs[i].mb, -1,
           bcyc, mcap, nrise, all1, held);
      check($sformatf("v%0d_busy_cycles", i), 32'(bcyc), 32'(vecs[i].bc));
      check($sformatf("v%0d_mosi_bits", i), 32'(mcap), 32'(vecs[i].emosi));
      check($sformatf("v%0d_shift_out", i), 32'(shift_out), 32'(vecs[i].eso));
      check($sformatf("v%0d_sclk_rises", i), 32'(nrise), 32'd8);
      check($sformatf("v%0d_sclk_idle", i), 32'(sclk), 32'd0);
      check($sformatf("v%0d_mosi_idle", i), 32'(mosi), 32'd1);
      check($sformatf("v%0d_shift_out_held", i), 32'(held), 32'd1);
      if (vecs[i].r && !vecs[i].w)
        check($sformatf("v%0d_read_mosi_high", i), 32'(all1), 32'd1);
    end

    // start_read injected mid-transfer must not disturb anything
    xfer(1'b1, 1'b0, 2'd2, 8'h5A, 8'hC3, 10, bcyc, mcap, nrise, all1, held);
    check("inj_busy_cycles", 32'(bcyc), 32'd32);
    check("inj_mosi_bits", 32'(mcap), 32'h5A);
    check("inj_shift_out", 32'(shift_out), 32'hC3);
    @(negedge clk);
    check("inj_no_restart", 32'(busy), 32'd0);

    // CRC over transmitted bits of "123456789"
    crc_reset = 1'b1;
    @(negedge clk);
    crc_reset = 1'b0;
    check("crc_cleared", 32'(crc_out), 32'h0000);
    crc_source = 1'b0;
    for (int i = 0; i < 9; i++)
      xfer(1'b1, 1'b0, 2'd3, 8'h31 + 8'(i), 8'h00, -1, bcyc, mcap, nrise, all1, held);
    check("crc_tx_123456789", 32'(crc_out), 32'h31C3);

    // Same message over received bits with miso looped back
    crc_reset = 1'b1;
    @(negedge clk);
    crc_reset = 1'b0;
    crc_source = 1'b1;
    loopback   = 1'b1;
    for (int i = 0; i < 9; i++)
      xfer(1'b1, 1'b0, 2'd3, 8'h31 + 8'(i), 8'h00, -1, bcyc, mcap, nrise, all1, held);
    check("crc_rx_123456789", 32'(crc_out), 32'h31C3);
    check("loop_shift_out", 32'(shift_out), 32'h39);
    loopback   = 1'b0;
    crc_source = 1'b0;

    // Slow speed: measure the first low and high phases, then reset mid-transfer
    mbyte = 8'hAA;
    rises = 0;
    start_write = 1'b1;
    speed       = 2'd0;
    shift_in    = 8'h96;
    @(negedge clk);
    start_write = 1'b0;
    n = 0;
    while (!sclk && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("slow_low_phase", 32'(n), 32'd128);
    n = 0;
    while (sclk && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("slow_high_phase", 32'(n), 32'd128);
    repeat (20) @(negedge clk);
    check("slow_still_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_shift_out", 32'(shift_out), 32'h00);
    check("abort_crc", 32'(crc_out), 32'h0000);
    @(negedge clk);
    rst = 1'b0;

    xfer(1'b1, 1'b0, 2'd3, 8'hC6, 8'h69, -1, bcyc, mcap, nrise, all1, held);
    check("post_rst_busy_cycles", 32'(bcyc), 32'd16);
    check("post_rst_mosi_bits", 32'(mcap), 32'hC6);
    check("post_rst_shift_out", 32'(shift_out), 32'h69);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
